// File: rtl/conv_pkg.sv
// Shared types and limits for the 3x3 convolution layer controller.
package conv_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_CHECK,
        S_LOAD_BRAM,
        S_LOAD_REG,
        S_WAIT_IDLE,
        S_STREAM,
        S_WAIT_ROW,
        S_DRAIN,
        S_ADVANCE,
        S_NEXT_OCH,
        S_DONE,
        S_ABORT
    } state_t;

    typedef enum logic [1:0] {
        ROW_FIRST,
        ROW_MID,
        ROW_LAST
    } row_kind_t;

    localparam int unsigned MIN_IMAGE_SIZE = 2;
    localparam int unsigned MIN_IN_CH      = 1;
    localparam int unsigned MIN_OUT_CH     = 1;

    // Top padding wins over bottom padding; images are at least 2 rows tall.
    function automatic row_kind_t row_kind(input logic is_first, input logic is_last);
        if (is_first) begin
            return ROW_FIRST;
        end else if (is_last) begin
            return ROW_LAST;
        end else begin
            return ROW_MID;
        end
    endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// Row / input-channel / output-channel counters with wrap detection.
module conv_loop_counter
    import conv_pkg::*;
#(
    parameter int unsigned IW = 9,
    parameter int unsigned CW = 10,
    parameter int unsigned OW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_row_i,
    input  logic          inc_ich_i,
    input  logic          inc_och_i,
    input  logic [IW-1:0] last_row_i,
    input  logic [CW-1:0] last_ich_i,
    input  logic [OW-1:0] last_och_i,
    output logic [IW-1:0] row_o,
    output logic [CW-1:0] ich_o,
    output logic [OW-1:0] och_o,
    output logic          row_wrap_o,
    output logic          ich_wrap_o,
    output logic          och_wrap_o
);

    logic [IW-1:0] row_q, row_d;
    logic [CW-1:0] ich_q, ich_d;
    logic [OW-1:0] och_q, och_d;

    assign row_wrap_o = (row_q == last_row_i);
    assign ich_wrap_o = (ich_q == last_ich_i);
    assign och_wrap_o = (och_q == last_och_i);

    always_comb begin
        row_d = row_q;
        ich_d = ich_q;
        och_d = och_q;
        if (clr_i) begin
            row_d = '0;
            ich_d = '0;
            och_d = '0;
        end else begin
            if (inc_row_i) begin
                row_d = row_wrap_o ? '0 : row_q + IW'(1);
            end
            if (inc_ich_i) begin
                ich_d = ich_wrap_o ? '0 : ich_q + CW'(1);
            end
            if (inc_och_i) begin
                och_d = och_wrap_o ? '0 : och_q + OW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= '0;
            ich_q <= '0;
            och_q <= '0;
        end else begin
            row_q <= row_d;
            ich_q <= ich_d;
            och_q <= och_d;
        end
    end

    assign row_o = row_q;
    assign ich_o = ich_q;
    assign och_o = och_q;

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer: kernel BRAM load, kernel register load and padded row streaming
// over every input and output channel.
module conv_layer_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned MAX_IMAGE_SIZE = 256,
    parameter int unsigned MAX_IN_CH      = 512,
    parameter int unsigned MAX_OUT_CH     = 512,
    parameter int unsigned IW             = $clog2(MAX_IMAGE_SIZE + 1),
    parameter int unsigned CW             = $clog2(MAX_IN_CH + 1),
    parameter int unsigned OW             = $clog2(MAX_OUT_CH + 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          start,
    input  logic          abort,
    input  logic [IW-1:0] cfg_image_size,
    input  logic [CW-1:0] cfg_in_ch,
    input  logic [OW-1:0] cfg_out_ch,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic          slave_select,
    output logic          sub_rst_n,
    input  logic          kbram_idle,
    output logic          kbram_load,
    input  logic          kbram_last,
    output logic          kbram_advance,
    output logic          kreg_load,
    input  logic          pe_ready,
    input  logic          lb_idle,
    input  logic          pe_idle,
    output logic          stream_first,
    output logic          stream_mid,
    output logic          stream_last,
    input  logic          row_done,
    output logic [IW-1:0] row_idx,
    output logic [CW-1:0] ich_idx,
    output logic [OW-1:0] och_idx
);

    state_t        state_q, state_d;
    logic [IW-1:0] image_q;
    logic [CW-1:0] in_ch_q;
    logic [OW-1:0] out_ch_q;

    logic      cnt_clr, inc_row, inc_ich, inc_och;
    logic      row_wrap, ich_wrap, och_wrap;
    logic      cfg_ok, sub_hold;
    row_kind_t kind;

    assign cfg_ok = (image_q  >= IW'(MIN_IMAGE_SIZE)) && (image_q  <= IW'(MAX_IMAGE_SIZE)) &&
                    (in_ch_q  >= CW'(MIN_IN_CH))      && (in_ch_q  <= CW'(MAX_IN_CH))      &&
                    (out_ch_q >= OW'(MIN_OUT_CH))     && (out_ch_q <= OW'(MAX_OUT_CH));

    conv_loop_counter #(
        .IW(IW),
        .CW(CW),
        .OW(OW)
    ) u_cnt (
        .clk_i      (clk),
        .rst_ni     (aresetn),
        .clr_i      (cnt_clr),
        .inc_row_i  (inc_row),
        .inc_ich_i  (inc_ich),
        .inc_och_i  (inc_och),
        .last_row_i (image_q - IW'(1)),
        .last_ich_i (in_ch_q - CW'(1)),
        .last_och_i (out_ch_q - OW'(1)),
        .row_o      (row_idx),
        .ich_o      (ich_idx),
        .och_o      (och_idx),
        .row_wrap_o (row_wrap),
        .ich_wrap_o (ich_wrap),
        .och_wrap_o (och_wrap)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            image_q  <= '0;
            in_ch_q  <= '0;
            out_ch_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                image_q  <= cfg_image_size;
                in_ch_q  <= cfg_in_ch;
                out_ch_q <= cfg_out_ch;
            end
        end
    end

    assign kind = row_kind(row_idx == '0, row_wrap);

    always_comb begin
        state_d       = state_q;
        cnt_clr       = 1'b0;
        inc_row       = 1'b0;
        inc_ich       = 1'b0;
        inc_och       = 1'b0;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
        cfg_err       = 1'b0;
        slave_select  = 1'b1;
        sub_hold      = 1'b0;
        kbram_load    = 1'b0;
        kbram_advance = 1'b0;
        kreg_load     = 1'b0;
        stream_first  = 1'b0;
        stream_mid    = 1'b0;
        stream_last   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    cnt_clr = 1'b1;
                end
            end
            S_CLEAR: begin
                sub_hold = 1'b1;
                cnt_clr  = 1'b1;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (!cfg_ok) begin
                    cfg_err = 1'b1;
                    state_d = S_IDLE;
                end else if (kbram_idle) begin
                    state_d = S_LOAD_BRAM;
                end
            end
            S_LOAD_BRAM: begin
                slave_select = 1'b0;
                kbram_load   = 1'b1;
                if (kbram_last) state_d = S_LOAD_REG;
            end
            S_LOAD_REG: begin
                kreg_load = 1'b1;
                if (pe_ready) state_d = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (lb_idle && pe_idle) state_d = S_STREAM;
            end
            S_STREAM: begin
                stream_first = (kind == ROW_FIRST);
                stream_mid   = (kind == ROW_MID);
                stream_last  = (kind == ROW_LAST);
                state_d      = S_WAIT_ROW;
            end
            S_WAIT_ROW: begin
                if (row_done) begin
                    inc_row = 1'b1;
                    state_d = row_wrap ? S_DRAIN : S_WAIT_IDLE;
                end
            end
            S_DRAIN: begin
                if (lb_idle && pe_idle) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                kbram_advance = 1'b1;
                inc_ich       = 1'b1;
                state_d       = ich_wrap ? S_NEXT_OCH : S_LOAD_REG;
            end
            S_NEXT_OCH: begin
                // The last output channel index is kept visible until the next start.
                if (och_wrap) begin
                    state_d = S_DONE;
                end else begin
                    inc_och = 1'b1;
                    state_d = S_LOAD_BRAM;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                sub_hold = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (abort && state_q != S_IDLE && state_q != S_ABORT) begin
            state_d = S_ABORT;
            cnt_clr = 1'b1;
            inc_row = 1'b0;
            inc_ich = 1'b0;
            inc_och = 1'b0;
        end
    end

    assign sub_rst_n = aresetn && !sub_hold;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed self-checking bench for conv_layer_ctrl with a simple reactive environment.
module tb_conv_layer_ctrl;

    localparam int IW = 9;
    localparam int CW = 10;
    localparam int OW = 10;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] cfg_image_size = '0;
    logic [CW-1:0] cfg_in_ch = '0;
    logic [OW-1:0] cfg_out_ch = '0;
    logic          kbram_idle = 1'b1;
    logic          kbram_last = 1'b0;
    logic          pe_ready = 1'b0;
    logic          lb_idle = 1'b1;
    logic          pe_idle = 1'b1;
    logic          row_done = 1'b0;

    logic          busy, done, cfg_err, slave_select, sub_rst_n;
    logic          kbram_load, kbram_advance, kreg_load;
    logic          stream_first, stream_mid, stream_last;
    logic [IW-1:0] row_idx;
    logic [CW-1:0] ich_idx;
    logic [OW-1:0] och_idx;

    conv_layer_ctrl #(
        .MAX_IMAGE_SIZE(256),
        .MAX_IN_CH(512),
        .MAX_OUT_CH(512)
    ) dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .start          (start),
        .abort          (abort),
        .cfg_image_size (cfg_image_size),
        .cfg_in_ch      (cfg_in_ch),
        .cfg_out_ch     (cfg_out_ch),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .slave_select   (slave_select),
        .sub_rst_n      (sub_rst_n),
        .kbram_idle     (kbram_idle),
        .kbram_load     (kbram_load),
        .kbram_last     (kbram_last),
        .kbram_advance  (kbram_advance),
        .kreg_load      (kreg_load),
        .pe_ready       (pe_ready),
        .lb_idle        (lb_idle),
        .pe_idle        (pe_idle),
        .stream_first   (stream_first),
        .stream_mid     (stream_mid),
        .stream_last    (stream_last),
        .row_done       (row_done),
        .row_idx        (row_idx),
        .ich_idx        (ich_idx),
        .och_idx        (och_idx)
    );

    always #5 clk = ~clk;

    // Environment: one-cycle BRAM load, instant kernel ready, row_done 3 cycles after a stream pulse.
    int n_first = 0, n_mid = 0, n_last = 0, n_adv = 0, n_done = 0, n_err = 0, n_loads = 0;
    int rd_timer = 0;
    logic prev_load = 1'b0;
    int och_log[$];

    always @(negedge clk) begin
        kbram_last = kbram_load;
        pe_ready   = kreg_load;
        row_done   = (rd_timer == 1);
        if (rd_timer > 0) rd_timer = rd_timer - 1;
        if (stream_first || stream_mid || stream_last) rd_timer = 3;
        n_first = n_first + int'(stream_first);
        n_mid   = n_mid   + int'(stream_mid);
        n_last  = n_last  + int'(stream_last);
        n_adv   = n_adv   + int'(kbram_advance);
        n_done  = n_done  + int'(done);
        n_err   = n_err   + int'(cfg_err);
        if (kbram_load && !prev_load) begin
            n_loads = n_loads + 1;
            och_log.push_back(int'(och_idx));
        end
        prev_load = kbram_load;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_layer(input int img, input int ic, input int oc);
        cfg_image_size = IW'(img);
        cfg_in_ch      = CW'(ic);
        cfg_out_ch     = OW'(oc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic bad_cfg(input string tag, input int img, input int ic, input int oc);
        int loads0;
        loads0 = n_loads;
        start_layer(img, ic, oc);
        check({tag, "_err_clear"}, 32'(cfg_err), 32'd0);
        tick();
        check({tag, "_err_pulse"}, 32'(cfg_err), 32'd1);
        tick();
        check({tag, "_err_gone"}, 32'(cfg_err), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_no_load"}, 32'(n_loads - loads0), 32'd0);
    endtask

    initial begin
        bit seen;
        int f0, m0, l0, a0, d0, ld0, q0;

        // Reset state
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sub_rst_n", 32'(sub_rst_n), 32'd0);
        check("rst_slave_select", 32'(slave_select), 32'd1);
        check("rst_kbram_load", 32'(kbram_load), 32'd0);
        check("rst_row_idx", 32'(row_idx), 32'd0);
        aresetn = 1'b1;
        tick();
        check("post_rst_sub_rst_n", 32'(sub_rst_n), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // image=4, in_ch=2, out_ch=1
        f0 = n_first; m0 = n_mid; l0 = n_last; a0 = n_adv; d0 = n_done; ld0 = n_loads;
        start_layer(4, 2, 1);
        check("s1_clear_sub_rst_n", 32'(sub_rst_n), 32'd0);
        check("s1_clear_busy", 32'(busy), 32'd1);
        wait_done(500, seen);
        check("s1_done_seen", 32'(seen), 32'd1);
        check("s1_first", 32'(n_first - f0), 32'd2);
        check("s1_mid", 32'(n_mid - m0), 32'd4);
        check("s1_last", 32'(n_last - l0), 32'd2);
        check("s1_advance", 32'(n_adv - a0), 32'd2);
        check("s1_loads", 32'(n_loads - ld0), 32'd1);
        check("s1_row_idx", 32'(row_idx), 32'd0);
        check("s1_ich_idx", 32'(ich_idx), 32'd0);
        check("s1_busy_at_done", 32'(busy), 32'd1);
        tick();
        check("s1_busy_after", 32'(busy), 32'd0);
        check("s1_done_count", 32'(n_done - d0), 32'd1);

        // image=2, in_ch=1, out_ch=3
        f0 = n_first; m0 = n_mid; l0 = n_last; a0 = n_adv; d0 = n_done; ld0 = n_loads;
        q0 = och_log.size();
        start_layer(2, 1, 3);
        wait_done(500, seen);
        check("s2_done_seen", 32'(seen), 32'd1);
        check("s2_first", 32'(n_first - f0), 32'd3);
        check("s2_mid", 32'(n_mid - m0), 32'd0);
        check("s2_last", 32'(n_last - l0), 32'd3);
        check("s2_advance", 32'(n_adv - a0), 32'd3);
        check("s2_loads", 32'(n_loads - ld0), 32'd3);
        check("s2_och_final", 32'(och_idx), 32'd2);
        if (och_log.size() >= q0 + 3) begin
            check("s2_och_seq0", 32'(och_log[q0]), 32'd0);
            check("s2_och_seq1", 32'(och_log[q0 + 1]), 32'd1);
            check("s2_och_seq2", 32'(och_log[q0 + 2]), 32'd2);
        end else begin
            check("s2_och_log_len", 32'(och_log.size() - q0), 32'd3);
        end
        tick();
        check("s2_done_count", 32'(n_done - d0), 32'd1);

        // Illegal configurations
        bad_cfg("cfg_img1", 1, 1, 1);
        bad_cfg("cfg_ich0", 4, 0, 1);
        bad_cfg("cfg_img257", 257, 1, 1);

        // Abort during WAIT_ROW of row 2
        d0 = n_done;
        start_layer(4, 1, 1);
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (stream_mid && row_idx == IW'(2)) begin
                seen = 1'b1;
                break;
            end
        end
        check("ab_row2_seen", 32'(seen), 32'd1);
        tick();
        check("ab_wait_row_idx", 32'(row_idx), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_sub_rst_low", 32'(sub_rst_n), 32'd0);
        check("ab_row_cleared", 32'(row_idx), 32'd0);
        tick();
        check("ab_sub_rst_high", 32'(sub_rst_n), 32'd1);
        check("ab_busy_low", 32'(busy), 32'd0);
        repeat (10) tick();
        check("ab_no_done", 32'(n_done - d0), 32'd0);

        // Restart, then stall the line buffer after the first row
        d0 = n_done;
        start_layer(3, 1, 1);
        check("rs_row0", 32'(row_idx), 32'd0);
        check("rs_ich0", 32'(ich_idx), 32'd0);
        check("rs_och0", 32'(och_idx), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (stream_first || stream_mid || stream_last) begin
                seen = 1'b1;
                break;
            end
        end
        check("rs_first_pulse", 32'(stream_first), 32'd1);
        check("rs_first_row", 32'(row_idx), 32'd0);
        lb_idle = 1'b0;
        f0 = n_first; m0 = n_mid; l0 = n_last;
        for (int k = 0; k < 53; k++) begin
            if (k == 10) begin
                start = 1'b1;
                cfg_image_size = IW'(8);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("st_no_stream", 32'((n_first - f0) + (n_mid - m0) + (n_last - l0)), 32'd0);
        check("st_row_idx", 32'(row_idx), 32'd1);
        check("st_busy", 32'(busy), 32'd1);
        lb_idle = 1'b1;
        wait_done(300, seen);
        check("st_done_seen", 32'(seen), 32'd1);
        check("st_first", 32'(n_first - f0), 32'd0);
        check("st_mid", 32'(n_mid - m0), 32'd1);
        check("st_last", 32'(n_last - l0), 32'd1);
        tick();
        check("st_done_count", 32'(n_done - d0), 32'd1);

        // Asynchronous reset mid-layer
        start_layer(4, 1, 2);
        repeat (15) tick();
        check("ar_busy_before", 32'(busy), 32'd1);
        aresetn = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_sub_rst_n", 32'(sub_rst_n), 32'd0);
        check("ar_slave_select", 32'(slave_select), 32'd1);
        check("ar_kreg_load", 32'(kreg_load), 32'd0);
        check("ar_kbram_load", 32'(kbram_load), 32'd0);
        check("ar_stream", 32'({stream_first, stream_mid, stream_last}), 32'd0);
        check("ar_idx", 32'({row_idx, ich_idx, och_idx}), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        check("ar_release_sub_rst_n", 32'(sub_rst_n), 32'd1);
        check("ar_release_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
